// File: rtl/debounce_pkg.sv
// Shared types and limits for the debounce filter and its synchroniser.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW   = 2'b00,
        CHECK_HIGH = 2'b01,
        IDLE_HIGH  = 2'b11,
        CHECK_LOW  = 2'b10
    } state_t;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    // Keeps an out-of-range stage count from building an unsafe or oversized chain.
    function automatic int clamp_sync_stages(input int n);
        if (n < SYNC_STAGES_MIN) return SYNC_STAGES_MIN;
        if (n > SYNC_STAGES_MAX) return SYNC_STAGES_MAX;
        return n;
    endfunction

endpackage

// File: rtl/debounce_sync_chain.sv
// Multi-flop synchroniser for a single asynchronous level; all flops clear on reset.
// Latency STAGES clocks from d_async to q_sync; no backpressure.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_sync,
    input  logic d_async,
    output logic q_sync
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d_async};
        end
    end

    assign q_sync = ff[STAGES-1];

endmodule

// File: rtl/debounce_filter.sv
// Debounces a raw level into dout with one-cycle rise/fall pulses; latency SYNC_STAGES+STABLE_CYCLES edges.
// Optional DEBOUNCE_TOGGLE_EN adds tgl, a push-on/push-off level flipped on every rise.
module debounce_filter
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 10000
) (
    input  logic clk,
    input  logic rst_sync,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
`ifdef DEBOUNCE_TOGGLE_EN
    ,
    output logic tgl
`endif
);

    localparam int SYNC_N = clamp_sync_stages(SYNC_STAGES);
    localparam int CNT_W  = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             dout_nxt, rise_nxt, fall_nxt, busy_nxt;

    sync_chain #(.STAGES(SYNC_N)) u_sync (
        .clk      (clk),
        .rst_sync (rst_sync),
        .d_async  (din),
        .q_sync   (s)
    );

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state <= IDLE_LOW;
            cnt   <= '0;
            dout  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dout  <= dout_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
            busy  <= busy_nxt;
        end
    end

    // Any sample disagreeing with the candidate level drops back to idle and restarts.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE_LOW: begin
                if (s) begin
                    state_nxt = CHECK_HIGH;
                    cnt_nxt   = CNT_W'(1);
                end else begin
                    cnt_nxt = '0;
                end
            end
            CHECK_HIGH: begin
                if (!s) begin
                    state_nxt = IDLE_LOW;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE_HIGH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            IDLE_HIGH: begin
                if (!s) begin
                    state_nxt = CHECK_LOW;
                    cnt_nxt   = CNT_W'(1);
                end else begin
                    cnt_nxt = '0;
                end
            end
            CHECK_LOW: begin
                if (s) begin
                    state_nxt = IDLE_HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE_LOW;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
        endcase
    end

    // Outputs are decoded from the next state so they land in flops alongside it.
    always_comb begin
        dout_nxt = state_nxt[1];
        busy_nxt = state_nxt[1] ^ state_nxt[0];
        rise_nxt = (state == CHECK_HIGH) && (state_nxt == IDLE_HIGH);
        fall_nxt = (state == CHECK_LOW)  && (state_nxt == IDLE_LOW);
    end

`ifdef DEBOUNCE_TOGGLE_EN
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            tgl <= 1'b0;
        end else if (rise_nxt) begin
            tgl <= ~tgl;
        end
    end
`endif

endmodule

// File: tb/tb_debounce_filter.sv
// Directed-vector bench for debounce_filter (SYNC_STAGES=2, STABLE_CYCLES=4) with a queued scoreboard.
module tb_debounce_filter;

    logic clk = 1'b0;
    logic rst_sync = 1'b1;
    logic din = 1'b0;
    logic dout, rise, fall, busy;
`ifdef DEBOUNCE_TOGGLE_EN
    logic tgl;
`endif

    always #5 clk = ~clk;

    debounce_filter #(.SYNC_STAGES(2), .STABLE_CYCLES(4)) dut (
        .clk      (clk),
        .rst_sync (rst_sync),
        .din      (din),
        .dout     (dout),
        .rise     (rise),
        .fall     (fall),
        .busy     (busy)
`ifdef DEBOUNCE_TOGGLE_EN
        ,
        .tgl      (tgl)
`endif
    );

    // Expected value after the edge following each vector: {tgl, dout, rise, fall, busy}.
    logic [4:0] exp_q[$];
    int  n_vec = 0;
    int  n_bad = 0;
    bit  done  = 1'b0;

    task automatic v(input logic r, input logic d, input logic [4:0] e);
        @(negedge clk);
        rst_sync = r;
        din      = d;
        exp_q.push_back(e);
    endtask

    initial begin
        v(1,0,5'b00000); v(1,0,5'b00000);
        // clean rising step: CHECK on edges 3-5, rise on edge 6
        v(0,1,5'b00000); v(0,1,5'b00000); v(0,1,5'b00001); v(0,1,5'b00001);
        v(0,1,5'b00001); v(0,1,5'b11100); v(0,1,5'b11000); v(0,1,5'b11000);
        // clean falling step
        v(0,0,5'b11000); v(0,0,5'b11000); v(0,0,5'b11001); v(0,0,5'b11001);
        v(0,0,5'b11001); v(0,0,5'b10010); v(0,0,5'b10000); v(0,0,5'b10000);
        // 2-cycle glitch rejected
        v(0,1,5'b10000); v(0,1,5'b10000); v(0,0,5'b10001); v(0,0,5'b10001);
        v(0,0,5'b10000); v(0,0,5'b10000);
        // 3-cycle glitch rejected
        v(0,1,5'b10000); v(0,1,5'b10000); v(0,1,5'b10001); v(0,0,5'b10001);
        v(0,0,5'b10001); v(0,0,5'b10000); v(0,0,5'b10000);
        // 4-cycle pulse accepted, then released
        v(0,1,5'b10000); v(0,1,5'b10000); v(0,1,5'b10001); v(0,1,5'b10001);
        v(0,0,5'b10001); v(0,0,5'b01100); v(0,0,5'b01001); v(0,0,5'b01001);
        v(0,0,5'b01001); v(0,0,5'b00010); v(0,0,5'b00000);
        // bounce 1,0,1,0,1 then settle high
        v(0,1,5'b00000); v(0,0,5'b00000); v(0,1,5'b00001); v(0,0,5'b00000);
        v(0,1,5'b00001); v(0,1,5'b00000); v(0,1,5'b00001); v(0,1,5'b00001);
        v(0,1,5'b00001); v(0,1,5'b11100); v(0,1,5'b11000); v(0,1,5'b11000);
        // release to low
        v(0,0,5'b11000); v(0,0,5'b11000); v(0,0,5'b11001); v(0,0,5'b11001);
        v(0,0,5'b11001); v(0,0,5'b10010); v(0,0,5'b10000); v(0,0,5'b10000);
        // press, reset at cnt=3, then full latency again after release
        v(0,1,5'b10000); v(0,1,5'b10000); v(0,1,5'b10001); v(0,1,5'b10001);
        v(0,1,5'b10001); v(1,1,5'b00000);
        v(0,1,5'b00000); v(0,1,5'b00000); v(0,1,5'b00001); v(0,1,5'b00001);
        v(0,1,5'b00001); v(0,1,5'b11100); v(0,1,5'b11000);
        @(negedge clk);
        done = 1'b1;
    end

    initial begin
        int         cycles;
        logic [4:0] e;
        logic       ok;
        cycles = 0;
        while (!(done && exp_q.size() == 0)) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles > 400) begin
                $display("FAIL timeout: %0d expected vectors still queued after %0d cycles", exp_q.size(), cycles);
                n_bad++;
                break;
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                ok = ({dout, rise, fall, busy} === e[3:0]);
`ifdef DEBOUNCE_TOGGLE_EN
                ok = ok && (tgl === e[4]);
                if (!ok) begin
                    $display("FAIL vec%0d: tgl/dout/rise/fall/busy got %b required %b",
                             n_vec, {tgl, dout, rise, fall, busy}, e);
                    n_bad++;
                end
`else
                if (!ok) begin
                    $display("FAIL vec%0d: dout/rise/fall/busy got %b required %b",
                             n_vec, {dout, rise, fall, busy}, e[3:0]);
                    n_bad++;
                end
`endif
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
